// File: rtl/vga_sync_decoder_if.sv
// vga_sync_decoder_if: VGA pin bundle plus recovered timing and pixel outputs
interface vga_sync_decoder_if;
  logic hsync, vsync, red, grn, blu;
  logic [9:0] col, row, line_len;
  logic [2:0] pixel_rgb;
  logic active, frame_start, locked, sync_err;
  modport master (output hsync, vsync, red, grn, blu,
                  input col, row, line_len, pixel_rgb, active, frame_start, locked, sync_err);
  modport slave (input hsync, vsync, red, grn, blu,
                 output col, row, line_len, pixel_rgb, active, frame_start, locked, sync_err);
endinterface

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers VGA pixel position from syncs, checks timing and reports lock
module vga_sync_decoder #(
  parameter int H_VISIBLE_AREA = 640,
  parameter int H_FRONT_PORCH = 18,
  parameter int H_SYNC_PULSE = 92,
  parameter int H_BACK_PORCH = 50,
  parameter int V_VISIBLE_AREA = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_PULSE = 12,
  parameter int V_BACK_PORCH = 33,
  parameter int LOCK_FRAMES = 2
) (
  input logic clk,
  input logic rst_n,
  vga_sync_decoder_if.slave vga
);
  localparam logic [9:0] H_LOAD = 10'(H_VISIBLE_AREA + H_FRONT_PORCH);
  localparam logic [9:0] H_LAST = 10'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH - 1);
  localparam logic [9:0] V_LOAD = 10'(V_VISIBLE_AREA + V_FRONT_PORCH);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH - 1);
  localparam logic [9:0] H_VIS = 10'(H_VISIBLE_AREA);
  localparam logic [9:0] V_VIS = 10'(V_VISIBLE_AREA);
  localparam logic [3:0] F_LAST = 4'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {SEARCH, HLOCK, CHECK, LOCKED} state_t;
  state_t state;

  logic s_h, s_v, p_h, p_v, h_seen;
  logic [2:0] s_rgb, pix;
  logic [9:0] col, row, lcnt, len;
  logic [3:0] fcnt;
  logic act, fs, lk, serr;
  logic h_fall, v_fall, h_err, v_err, err, lock_n, act_n;
  logic [9:0] col_inc, row_inc, col_n, row_n;

  // predictions are what free-running counters would show next; errors compare edges against them
  always_comb begin
    h_fall = p_h & ~s_h;
    v_fall = p_v & ~s_v;
    col_inc = (col == H_LAST) ? '0 : col + 10'd1;
    row_inc = (col != H_LAST) ? row : (row == V_LAST) ? '0 : row + 10'd1;
    col_n = h_fall ? H_LOAD : col_inc;
    row_n = v_fall ? V_LOAD : row_inc;
    h_err = (state != SEARCH) && ((h_fall && col_inc != H_LOAD) || (col_inc == H_LOAD && s_h));
    v_err = (state == CHECK || state == LOCKED) && v_fall && row_inc != V_LOAD;
    err = h_err | v_err;
    lock_n = !err && (state == LOCKED || (state == CHECK && v_fall && fcnt == F_LAST));
    act_n = lock_n && col_n < H_VIS && row_n < V_VIS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_h <= 1'b1;
      s_v <= 1'b1;
      p_h <= 1'b1;
      p_v <= 1'b1;
      s_rgb <= '0;
      col <= '0;
      row <= '0;
      lcnt <= '0;
      len <= '0;
      h_seen <= 1'b0;
      fcnt <= '0;
      state <= SEARCH;
      serr <= 1'b0;
      lk <= 1'b0;
      act <= 1'b0;
      pix <= '0;
      fs <= 1'b0;
    end else begin
      s_h <= vga.hsync;
      s_v <= vga.vsync;
      p_h <= s_h;
      p_v <= s_v;
      s_rgb <= {vga.red, vga.grn, vga.blu};
      col <= col_n;
      row <= row_n;
      lcnt <= h_fall ? 10'd1 : (lcnt == 10'h3ff) ? lcnt : lcnt + 10'd1;
      len <= (h_fall && h_seen) ? lcnt : len;
      h_seen <= h_seen | h_fall;
      serr <= err;
      lk <= lock_n;
      act <= act_n;
      pix <= act_n ? s_rgb : 3'b000;
      fs <= lock_n && col_n == '0 && row_n == '0;
      if (err) state <= SEARCH;
      else case (state)
        SEARCH: if (h_fall) state <= HLOCK;
        HLOCK: if (v_fall) begin
          fcnt <= '0;
          state <= CHECK;
        end
        CHECK: if (v_fall) begin
          fcnt <= fcnt + 4'd1;
          if (fcnt == F_LAST) state <= LOCKED;
        end
        default: ;
      endcase
    end
  end

  assign vga.col = col;
  assign vga.row = row;
  assign vga.line_len = len;
  assign vga.pixel_rgb = pix;
  assign vga.active = act;
  assign vga.frame_start = fs;
  assign vga.locked = lk;
  assign vga.sync_err = serr;
endmodule
